svga_sync_decoder: RTL and testbench
====================================

// Module: svga_sync_decoder
// PURPOSE
//  Receive-side companion to the SVGA sync generator. Takes the positive-polarity
//  hsync/vsync pair in the pixel-clock domain and measures line and frame timing.
//  Locks to the configured 800x600 mode and recovers the pixel position (x, y)
//  and a data-enable (de) for downstream capture or compare logic.
//  Flags timing faults so loopback benches and board self-test can detect a bad generator.
// PARAMETERS
//  H_TOTAL      1056  expected pixel clocks per line (hsync rise to hsync rise)
//  V_TOTAL      628   expected lines per frame
//  H_START      216   clocks from hsync rise (hcnt=0) to first active pixel
//  V_START      27    lines from frame line 0 to first active line
//  H_ACTIVE     800   active pixels per line
//  V_ACTIVE     600   active lines per frame
//  LOCK_FRAMES  2     consecutive good frames required to assert locked
// PORTS
//  clk          in   1   pixel clock (40 MHz); hsync_in/vsync_in are synchronous to it
//  rst_n        in   1   asynchronous, active-low reset
//  hsync_in     in   1   horizontal sync, active high
//  vsync_in     in   1   vertical sync, active high
//  de           out  1   active-pixel strobe; only asserted while locked
//  x            out  11  active column 0..H_ACTIVE-1; 0 when de=0
//  y            out  10  active line 0..V_ACTIVE-1; 0 when de=0
//  locked       out  1   timing matches parameters
//  frame_start  out  1   1-clock pulse when frame line 0 begins
//  err          out  1   1-clock pulse on timing fault while in CHECK or LOCKED
//  h_period     out  11  last measured line length, in clocks
//  v_period     out  10  last measured frame length, in lines
//  hs_width     out  8   last measured hsync width, in clocks
//  vs_width     out  4   last measured vsync width, in hsync edges
// BEHAVIOUR
//  Reset: every output and counter is 0. The FSM enters SEARCH.
//  Inputs are registered once (hs_q, vs_q), then delayed once more for edge detect.
//  hrise = hs_q & ~hs_q_d. vrise is formed the same way. Input-to-de/x/y latency is fixed at 3 clocks.
//  hcnt (11b): 0 on hrise, else +1; saturates at 2047.
//   - On saturation: timeout. FSM goes to SEARCH, err pulses once.
//  h_period: on hrise, h_period <= hcnt+1. Skipped on the first hrise after reset or timeout.
//  hs_width: counts while hs_q=1; latched on the hs_q falling edge; saturates at 255.
//  vrise sets v_arm. The next hrise (or the same cycle) does all of the following:
//   - vcnt <= 0, v_period <= vcnt+1, clears v_arm, pulses frame_start.
//   - Any other hrise: vcnt <= vcnt+1, saturating at 1023.
//  vs_width: hsync edges counted while vs_q=1; latched on the vs_q fall.
//  Line check: each measured h_period != H_TOTAL sets line_bad.
//  Frame check: at the frame boundary, frame_bad = line_bad | (v_period != V_TOTAL).
//   - line_bad clears at every frame boundary.
//  FSM:
//   - SEARCH -> CHECK at the first frame boundary; good_cnt=0.
//   - CHECK: good frame does good_cnt+1; at LOCK_FRAMES -> LOCKED.
//     Bad frame pulses err, good_cnt=0, stays in CHECK.
//   - LOCKED: a line mismatch pulses err in the same cycle and goes -> SEARCH; locked drops next clock.
//     So does a bad v_period at the boundary.
//  Timeout in any state -> SEARCH; err pulses once, only in CHECK or LOCKED.
//  de is registered: locked & H_START<=hcnt<H_START+H_ACTIVE & V_START<=vcnt<V_START+V_ACTIVE.
//   - x = hcnt-H_START and y = vcnt-V_START, registered alongside de.
//  Simultaneous vrise and hrise: treat as vrise first (the same hrise resets vcnt).
//  Reset asserted mid-frame clears everything immediately; relock needs LOCK_FRAMES+1 boundaries.
// TESTING
//  1 Nominal 1056x628 stream, hs 128 clk, vs 4 lines -> locked rises at the 3rd frame boundary.
//    Then 800 de/line, 480000 de/frame, x 0..799, y 0..599, hs_width=128, vs_width=4.
//  2 While locked, one line of 1055 clocks -> h_period=1055, err pulse.
//    locked=0 next clock, relock after 2 good frames.
//  3 Hold hsync low for 3000 clocks while locked -> err pulse and locked=0 at hcnt saturation.
//    de stays 0 until relock.
//  4 Frame of 627 lines -> v_period=627 at the boundary, err, locked=0.
//  5 vsync rise on the same clock as hsync rise -> vcnt=0 on that line, frame_start pulses once.
//  6 rst_n low for 5 clocks mid-active-line -> all outputs 0 asynchronously, relock proceeds as in test 1.

Source files
------------

// File: rtl/svga_sync_decoder.sv
// -----------------------------------------------------------------------------
// svga_sync_decoder
// Receive-side timing decoder for a positive-polarity hsync/vsync pair in the
// pixel-clock domain. It measures line/frame timing, locks to the configured
// mode, recovers the active pixel position (x, y) with a data-enable, and
// pulses err when the incoming timing stops matching the configured mode.
//
// Ports
//   clk          in   pixel clock; hsync_in/vsync_in are synchronous to it
//   rst_n        in   asynchronous active-low reset
//   hsync_in     in   horizontal sync, active high
//   vsync_in     in   vertical sync, active high
//   de           out  active-pixel strobe, only while locked
//   x            out  active column, 0 when de=0
//   y            out  active line, 0 when de=0
//   locked       out  timing matches the parameters
//   frame_start  out  1-clock pulse when frame line 0 begins
//   err          out  1-clock pulse on a timing fault in CHECK or LOCKED
//   h_period     out  last measured line length (clocks)
//   v_period     out  last measured frame length (lines)
//   hs_width     out  last measured hsync width (clocks)
//   vs_width     out  last measured vsync width (hsync edges)
// -----------------------------------------------------------------------------
module svga_sync_decoder #(
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int H_START     = 216,
  parameter int V_START     = 27,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [10:0] h_period,
  output logic [9:0]  v_period,
  output logic [7:0]  hs_width,
  output logic [3:0]  vs_width
);

  localparam logic [10:0] L_H_TOTAL = 11'(H_TOTAL);
  localparam logic [9:0]  L_V_TOTAL = 10'(V_TOTAL);
  localparam logic [10:0] L_H_START = 11'(H_START);
  localparam logic [10:0] L_H_END   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  L_V_START = 10'(V_START);
  localparam logic [9:0]  L_V_END   = 10'(V_START + V_ACTIVE);
  localparam logic [3:0]  L_LOCK    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_good_cnt;
  logic [3:0]  w_good_nxt;
  logic        w_err_nxt;

  logic        r_hs_q, r_hs_d, r_vs_q, r_vs_d;
  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_h_valid;
  logic        r_v_arm;
  logic        r_line_bad;
  logic [7:0]  r_hs_cnt;
  logic [3:0]  r_vs_cnt;

  logic        r_de;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_locked;
  logic        r_frame_start;
  logic        r_err;
  logic [10:0] r_h_period;
  logic [9:0]  r_v_period;
  logic [7:0]  r_hs_width;
  logic [3:0]  r_vs_width;

  logic        w_hrise, w_vrise, w_hs_fall, w_vs_fall;
  logic        w_timeout;
  logic [10:0] w_h_meas;
  logic [9:0]  w_v_meas;
  logic        w_h_update;
  logic        w_line_mis;
  logic        w_vbound;
  logic        w_v_bad;
  logic        w_frame_bad;
  logic        w_de_nxt;

  assign w_hrise    = r_hs_q & ~r_hs_d;
  assign w_vrise    = r_vs_q & ~r_vs_d;
  assign w_hs_fall  = ~r_hs_q & r_hs_d;
  assign w_vs_fall  = ~r_vs_q & r_vs_d;
  // Fires only on the step into saturation, so a long stall reports once.
  assign w_timeout  = ~w_hrise & (r_hcnt == 11'd2046);
  assign w_h_meas   = r_hcnt + 11'd1;
  assign w_v_meas   = r_vcnt + 10'd1;
  // The first hrise after reset/timeout closes a partial line: not measured.
  assign w_h_update = w_hrise & r_h_valid;
  assign w_line_mis = w_h_update & (w_h_meas != L_H_TOTAL);
  // A vrise coincident with hrise makes that same hrise the frame boundary.
  assign w_vbound   = w_hrise & (r_v_arm | w_vrise);
  assign w_v_bad    = w_v_meas != L_V_TOTAL;
  // The line closed by the boundary hrise still belongs to the ending frame.
  assign w_frame_bad = r_line_bad | w_line_mis | w_v_bad;

  assign w_de_nxt = (r_state == ST_LOCKED) &
                    (r_hcnt >= L_H_START) & (r_hcnt < L_H_END) &
                    (r_vcnt >= L_V_START) & (r_vcnt < L_V_END);

  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign err         = r_err;
  assign h_period    = r_h_period;
  assign v_period    = r_v_period;
  assign hs_width    = r_hs_width;
  assign vs_width    = r_vs_width;

  // Lock FSM next-state, good-frame counter and error pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_err_nxt   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = 4'd0;
      w_err_nxt   = (r_state != ST_SEARCH);
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_vbound) begin
            w_state_nxt = ST_CHECK;
            w_good_nxt  = 4'd0;
          end else begin
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_CHECK: begin
          if (w_vbound) begin
            if (w_frame_bad) begin
              w_err_nxt  = 1'b1;
              w_good_nxt = 4'd0;
            end else if ((r_good_cnt + 4'd1) >= L_LOCK) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = r_good_cnt + 4'd1;
            end else begin
              w_good_nxt = r_good_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_LOCKED: begin
          if (w_line_mis | (w_vbound & w_v_bad)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = 4'd0;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = 4'd0;
        end
      endcase
    end
  end

  // FSM state, error pulse and locked flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= 4'd0;
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_err      <= w_err_nxt;
      r_locked   <= (r_state == ST_LOCKED);
    end
  end

  // Input capture and one-clock delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_q <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_q <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs_q <= hsync_in;
      r_hs_d <= r_hs_q;
      r_vs_q <= vsync_in;
      r_vs_d <= r_vs_q;
    end
  end

  // Horizontal counter, line-period measurement and line-fault tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt     <= 11'd0;
      r_h_valid  <= 1'b0;
      r_h_period <= 11'd0;
      r_line_bad <= 1'b0;
    end else begin
      if (w_hrise) begin
        r_hcnt <= 11'd0;
      end else if (r_hcnt != 11'd2047) begin
        r_hcnt <= r_hcnt + 11'd1;
      end
      if (w_timeout) begin
        r_h_valid <= 1'b0;
      end else if (w_hrise) begin
        r_h_valid <= 1'b1;
      end
      if (w_h_update) begin
        r_h_period <= w_h_meas;
      end
      if (w_vbound) begin
        r_line_bad <= 1'b0;
      end else if (w_line_mis) begin
        r_line_bad <= 1'b1;
      end
    end
  end

  // Vertical counter, frame boundary detection and frame-period measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt        <= 10'd0;
      r_v_arm       <= 1'b0;
      r_v_period    <= 10'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_vbound;
      if (w_vbound) begin
        r_vcnt     <= 10'd0;
        r_v_period <= w_v_meas;
        r_v_arm    <= 1'b0;
      end else begin
        if (w_hrise && (r_vcnt != 10'd1023)) begin
          r_vcnt <= r_vcnt + 10'd1;
        end
        if (w_vrise) begin
          r_v_arm <= 1'b1;
        end
      end
    end
  end

  // Sync pulse width measurement, latched on each falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_cnt   <= 8'd0;
      r_vs_cnt   <= 4'd0;
      r_hs_width <= 8'd0;
      r_vs_width <= 4'd0;
    end else begin
      if (r_hs_q) begin
        if (r_hs_cnt != 8'd255) begin
          r_hs_cnt <= r_hs_cnt + 8'd1;
        end
      end else begin
        r_hs_cnt <= 8'd0;
      end
      if (w_hs_fall) begin
        r_hs_width <= r_hs_cnt;
      end
      if (r_vs_q) begin
        if (w_hrise && (r_vs_cnt != 4'd15)) begin
          r_vs_cnt <= r_vs_cnt + 4'd1;
        end
      end else begin
        r_vs_cnt <= 4'd0;
      end
      if (w_vs_fall) begin
        r_vs_width <= r_vs_cnt;
      end
    end
  end

  // Registered data-enable and active pixel coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de <= 1'b0;
      r_x  <= 11'd0;
      r_y  <= 10'd0;
    end else begin
      r_de <= w_de_nxt;
      r_x  <= w_de_nxt ? (r_hcnt - L_H_START) : 11'd0;
      r_y  <= w_de_nxt ? (r_vcnt - L_V_START) : 10'd0;
    end
  end

endmodule

// File: tb/tb_svga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_svga_sync_decoder
// Drives a small-format sync stream into svga_sync_decoder and checks locking,
// pixel coordinates, measurements and fault reporting. Expected (x, y) pairs are
// queued as the generator emits active pixels and compared as de appears.
// -----------------------------------------------------------------------------
module tb_svga_sync_decoder;

  localparam int HT = 40;
  localparam int VT = 20;
  localparam int HS = 10;
  localparam int VS = 3;
  localparam int HA = 24;
  localparam int VA = 12;
  localparam int HSW = 4;
  localparam int VSW = 3;
  localparam int VS_LATE = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in;
  logic        de, locked, frame_start, err;
  logic [10:0] x, h_period;
  logic [9:0]  y, v_period;
  logic [7:0]  hs_width;
  logic [3:0]  vs_width;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt = 0, err_cnt = 0, de_cnt = 0, idle_bad = 0;
  int lock_rise_fs = -1;
  logic prev_locked = 1'b0;
  logic late_mode = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] exp_xy;

  svga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de(de), .x(x), .y(y), .locked(locked), .frame_start(frame_start),
    .err(err), .h_period(h_period), .v_period(v_period),
    .hs_width(hs_width), .vs_width(vs_width)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on de, event counters.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_start) fs_cnt++;
      if (err) err_cnt++;
      if (locked && !prev_locked) lock_rise_fs = fs_cnt;
      if (de) begin
        de_cnt++;
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_errors++;
          $error("FAIL de_extra: observed de=1 x=%0d y=%0d, expected de=0", x, y);
        end
        if (exp_q.size() != 0) begin
          exp_xy = exp_q.pop_front();
          chk("xy", {11'd0, x, y}, {11'd0, exp_xy});
        end
      end else if (x != 11'd0 || y != 10'd0) begin
        idle_bad++;
      end
    end
    prev_locked = locked;
  end

  task automatic send_line(input int l, input int len, input int nlines, input bit exp_de);
    for (int col = 0; col < len; col++) begin
      @(posedge clk);
      #1;
      hsync_in = (col < HSW);
      if (late_mode)
        vsync_in = (l < VSW - 1) || (l == VSW - 1 && col < VS_LATE) ||
                   (l == nlines - 1 && col >= VS_LATE);
      else
        vsync_in = (l < VSW);
      if (exp_de && l >= VS && l < VS + VA && col >= HS && col < HS + HA)
        exp_q.push_back({11'(col - HS), 10'(l - VS)});
    end
  endtask

  task automatic send_frame(input int nlines, input bit exp_de);
    for (int l = 0; l < nlines; l++) send_line(l, HT, nlines, exp_de);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {de, locked, frame_start, err, x, y}, 32'd0);
    chk({tag, "_meas"}, {h_period, v_period, hs_width, vs_width}, 32'd0);
  endtask

  int fs0, de0, e0;

  initial begin
    rst_n = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // 1: nominal stream, lock at the third boundary
    fs0 = fs_cnt; de0 = de_cnt; e0 = err_cnt;
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b0);
    chk("locked_early", {31'd0, locked}, 32'd0);
    send_frame(VT, 1'b1);
    chk("locked", {31'd0, locked}, 32'd1);
    chk("lock_boundary", lock_rise_fs - fs0, 3);
    chk("de_per_frame", de_cnt - de0, HA * VA);
    chk("h_period", h_period, HT);
    chk("v_period", v_period, VT);
    chk("hs_width", hs_width, HSW);
    chk("vs_width", vs_width, VSW);
    chk("no_err", err_cnt - e0, 0);
    chk("queue_empty1", exp_q.size(), 0);
    fs0 = fs_cnt; de0 = de_cnt;
    send_frame(VT, 1'b1);
    chk("frame_start_once", fs_cnt - fs0, 1);
    chk("de_per_frame2", de_cnt - de0, HA * VA);

    // 2: one short line while locked
    e0 = err_cnt;
    for (int l = 0; l < 6; l++) send_line(l, (l == 5) ? HT - 1 : HT, VT, 1'b1);
    send_line(6, HT, VT, 1'b0);
    chk("h_period_short", h_period, HT - 1);
    chk("err_short", err_cnt - e0, 1);
    chk("unlock_short", {31'd0, locked}, 32'd0);
    chk("queue_empty2", exp_q.size(), 0);
    for (int l = 7; l < VT; l++) send_line(l, HT, VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b1);
    chk("relock_short", {31'd0, locked}, 32'd1);
    chk("err_short_once", err_cnt - e0, 1);

    // 3: hsync stalled, counter saturation timeout
    e0 = err_cnt; de0 = de_cnt;
    repeat (3000) begin
      @(posedge clk);
      #1;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
    end
    chk("err_timeout", err_cnt - e0, 1);
    chk("unlock_timeout", {31'd0, locked}, 32'd0);
    chk("de_timeout", de_cnt - de0, 0);
    send_line(0, HT, VT, 1'b0);
    chk("h_period_skip", h_period, HT);
    for (int l = 1; l < VT; l++) send_line(l, HT, VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b1);
    chk("relock_timeout", {31'd0, locked}, 32'd1);

    // 4: short frame while locked
    e0 = err_cnt;
    send_frame(VT - 1, 1'b1);
    send_line(0, HT, VT, 1'b0);
    chk("v_period_short", v_period, VT - 1);
    chk("err_vshort", err_cnt - e0, 1);
    chk("unlock_vshort", {31'd0, locked}, 32'd0);
    for (int l = 1; l < VT; l++) send_line(l, HT, VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b1);
    chk("relock_vshort", {31'd0, locked}, 32'd1);

    // 6: reset mid-active-line, then relock with vsync rising mid-line
    for (int l = 0; l < 5; l++) send_line(l, HT, VT, 1'b1);
    send_line(5, 20, VT, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    late_mode = 1'b1;
    fs0 = fs_cnt; de0 = de_cnt;
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b0);
    send_frame(VT, 1'b1);
    chk("relock_reset", lock_rise_fs - fs0, 3);
    chk("de_after_reset", de_cnt - de0, HA * VA);
    chk("v_period_late", v_period, VT);
    chk("vs_width_late", vs_width, VSW);
    chk("queue_empty_end", exp_q.size(), 0);
    chk("xy_zero_idle", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
